axis_oled_text_source: RTL and testbench
========================================

// Module: axis_oled_text_source
// PURPOSE
//   AXI-Stream master producing the four 128-bit text lines the OLED display sink latches.
//   - Captures four 32-bit status words.
//   - Formats each word as a 16-char ASCII line "CHn: 0xXXXXXXXX ".
//   - Presents all four lines as one beat, held under a tvalid/tready handshake.
//   - Sits between the status/register logic and the OLED display sink.
// PARAMETERS
//   UPPERCASE    1  1: hex digits A-F (0x41..); 0: a-f (0x61..)
//   AUTO_PERIOD  0  0: refresh only on start; N>0: self-start every N clocks, counted while IDLE
// PORTS
//   clk                 in   1    system clock; all logic on rising edge
//   reset               in   1    asynchronous, active-high
//   val0..val3          in   32   status words; sampled only on capture
//   start               in   1    request one refresh (single-cycle pulse or level)
//   busy                out  1    high whenever state != IDLE
//   m_axis_tdata_str1   out  128  line 1 text (CH1); char 0 in [127:120], char 15 in [7:0]
//   m_axis_tdata_str2   out  128  line 2 text (CH2), same packing
//   m_axis_tdata_str3   out  128  line 3 text (CH3), same packing
//   m_axis_tdata_str4   out  128  line 4 text (CH4), same packing
//   m_axis_tvalid       out  1    all four lines valid
//   m_axis_tready       in   1    sink accepts beat
// BEHAVIOUR
//   Reset values (async):
//   - m_axis_tdata_str1..4 = 128'h0, m_axis_tvalid = 0, busy = 0.
//   - Internal: state = IDLE, pending = 0, auto counter = 0.
//   FSM states: IDLE, FORMAT, VALID.
//   IDLE -> FORMAT when (start | pending | auto_tick) is high at a clock edge.
//   - That same edge captures val0..3 into a shadow register.
//   - That same edge clears pending.
//   FORMAT: one nibble per cycle, 32 cycles, nibble index 0..31.
//   - Index = line*8 + digit, most-significant nibble first.
//   - Each nibble is written to its ASCII slot in a build buffer; the outputs are not touched.
//   FORMAT -> VALID after index 31.
//   - The same edge copies the build buffer to m_axis_tdata_str1..4 and sets tvalid.
//   - start-to-tvalid latency: 33 clocks.
//   VALID: tdata and tvalid are held constant until (tvalid & tready).
//   - The handshake edge clears tvalid and moves to IDLE.
//   - tdata keeps the last line values after the handshake.
//   - Unbounded backpressure is legal; tvalid never drops without a handshake.
//   Line format, bytes 0..15:
//   - 'C','H', ASCII('1'+line), ':', ' ', '0', 'x', 8 hex digits, ' '.
//   - Fixed characters are constant in the build buffer; only digit slots are written.
//   Digit encoding:
//   - 0-9 -> 0x30-0x39.
//   - 10-15 -> 0x41-0x46 when UPPERCASE=1, 0x61-0x66 when UPPERCASE=0.
//   Start while busy (FORMAT or VALID):
//   - Sets pending (one deep); any further starts merge into it.
//   - The current formatting is not disturbed.
//   - Pending causes a fresh capture in the first IDLE cycle after the handshake (one IDLE cycle minimum).
//   AUTO_PERIOD>0:
//   - The counter increments only in IDLE.
//   - auto_tick fires when the count reaches AUTO_PERIOD-1; the counter clears on leaving IDLE.
//   - start and auto_tick in the same cycle give one refresh.
//   Reset mid-operation:
//   - Immediate return to IDLE with all outputs at reset values.
//   - The partially built buffer is discarded.
// STRUCTURE
//   Shared package oled_text_pkg:
//   - State encoding.
//   - ASCII constants ('C','H',':',' ','0','x').
//   - OLED_LINE_W = 128, OLED_CHARS = 16.
//   Sub-module nibble_to_ascii (combinational, parameter UPPERCASE): 4-bit in, 8-bit ASCII out.
//   Top level: FSM, 5-bit nibble index, shadow register, build buffer, output registers, auto counter.
// TESTING
//   1. val0=32'hDEADBEEF, start pulse, tready=1:
//      - tvalid rises 33 clocks later.
//      - str1 = "CH1: 0xDEADBEEF " (128'h4348313A_20307844_45414442_45454620).
//   2. val1=0, val2=32'h0123ABCD, UPPERCASE=0:
//      - str2 = "CH2: 0x00000000 ".
//      - str3 = "CH3: 0x0123abcd ".
//   3. tready=0 for 50 cycles after tvalid:
//      - tvalid and all tdata stay stable.
//      - Handshake on the first tready=1; tvalid low the next cycle.
//   4. Three start pulses during FORMAT, val0 changed to 32'h11111111 meanwhile:
//      - Exactly one extra beat follows the first.
//      - That beat shows CH1 0x11111111.
//   5. reset asserted at FORMAT nibble 10:
//      - Outputs are 0 and busy = 0 immediately.
//      - After reset release, the next start yields a correct, complete beat.
//   6. AUTO_PERIOD=100, start tied low, tready=1:
//      - Beats repeat periodically.
//      - No beats while reset is held.

Source files
------------

// File: rtl/oled_text_pkg.sv
// Shared definitions for the OLED text source: FSM encoding, fixed line characters
// and the helper that packs one 16-character line.
package oled_text_pkg;

    localparam int unsigned OLED_LINE_W = 128;
    localparam int unsigned OLED_CHARS  = 16;
    localparam int unsigned OLED_LINES  = 4;
    localparam int unsigned OLED_DIGITS = 8;

    typedef enum logic [1:0] {
        StIdle,
        StFormat,
        StValid
    } state_e;

    localparam logic [7:0] AsciiC     = 8'h43;
    localparam logic [7:0] AsciiH     = 8'h48;
    localparam logic [7:0] AsciiColon = 8'h3A;
    localparam logic [7:0] AsciiSpace = 8'h20;
    localparam logic [7:0] AsciiZero  = 8'h30;
    localparam logic [7:0] AsciiX     = 8'h78;

    // Builds "CHn: 0x<digits> "; char 0 lands in the top byte, digit 0 in digits[63:56].
    function automatic logic [OLED_LINE_W-1:0] make_line(input logic [1:0]  line,
                                                         input logic [63:0] digits);
        logic [7:0] line_char;
        line_char = AsciiZero + {6'd0, line} + 8'd1;
        return {AsciiC, AsciiH, line_char, AsciiColon, AsciiSpace, AsciiZero, AsciiX,
                digits, AsciiSpace};
    endfunction

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational hex-digit to ASCII converter; UPPERCASE selects the A-F or a-f range.
module nibble_to_ascii #(
    parameter bit UPPERCASE = 1'b1
) (
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    // Offset such that nibble 10 maps onto 'A' (0x41) or 'a' (0x61).
    localparam logic [7:0] AlphaBase = UPPERCASE ? 8'h37 : 8'h57;

    always_comb begin
        if (nibble_i < 4'd10) begin
            ascii_o = 8'h30 + {4'h0, nibble_i};
        end else begin
            ascii_o = AlphaBase + {4'h0, nibble_i};
        end
    end

endmodule

// File: rtl/axis_oled_text_source.sv
// AXI-Stream master that renders four captured status words as four 16-char hex text
// lines, one nibble per clock, and presents them as a single held beat.
module axis_oled_text_source
    import oled_text_pkg::*;
#(
    parameter bit          UPPERCASE   = 1'b1,
    parameter int unsigned AUTO_PERIOD = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            val0,
    input  logic [31:0]            val1,
    input  logic [31:0]            val2,
    input  logic [31:0]            val3,
    input  logic                   start,
    output logic                   busy,
    output logic [OLED_LINE_W-1:0] m_axis_tdata_str1,
    output logic [OLED_LINE_W-1:0] m_axis_tdata_str2,
    output logic [OLED_LINE_W-1:0] m_axis_tdata_str3,
    output logic [OLED_LINE_W-1:0] m_axis_tdata_str4,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready
);

    localparam logic [4:0]  IdxLast  = 5'd31;
    localparam logic [31:0] AutoLast = (AUTO_PERIOD > 0) ? 32'(AUTO_PERIOD - 1) : 32'd0;

    state_e state_q, state_d;

    logic [4:0]                   idx_q, idx_d;
    logic [OLED_LINES-1:0][31:0]  shadow_q;
    logic [OLED_LINES-1:0][63:0]  build_q, build_d;
    logic                         pending_q, pending_d;
    logic [31:0]                  auto_cnt_q, auto_cnt_d;

    logic       auto_tick;
    logic       go;
    logic       capture;
    logic       write_digit;
    logic       load_out;
    logic       handshake;
    logic [1:0] cur_line;
    logic [2:0] cur_digit;
    logic [3:0] cur_nibble;
    logic [7:0] cur_ascii;

    assign auto_tick = (AUTO_PERIOD > 0) && (state_q == StIdle) && (auto_cnt_q == AutoLast);
    assign go        = start | pending_q | auto_tick;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (go)                 state_d = StFormat;
            StFormat: if (idx_q == IdxLast)   state_d = StValid;
            StValid:  if (m_axis_tready)      state_d = StIdle;
            default:                          state_d = StIdle;
        endcase
    end

    always_comb begin
        busy        = (state_q != StIdle);
        capture     = (state_q == StIdle) && go;
        write_digit = (state_q == StFormat);
        load_out    = write_digit && (idx_q == IdxLast);
        handshake   = m_axis_tvalid && m_axis_tready;
    end

    // ---------------------------------------------------------------- control counters
    always_comb begin
        idx_d = idx_q;
        if (capture) begin
            idx_d = 5'd0;
        end else if (write_digit) begin
            idx_d = idx_q + 5'd1;
        end
    end

    // A start seen at the capture edge is consumed by that refresh, not queued.
    always_comb begin
        pending_d = pending_q;
        if (capture) begin
            pending_d = 1'b0;
        end else if (start && busy) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        auto_cnt_d = 32'd0;
        if ((AUTO_PERIOD > 0) && (state_q == StIdle) && !go) begin
            auto_cnt_d = auto_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q      <= 5'd0;
            pending_q  <= 1'b0;
            auto_cnt_q <= 32'd0;
        end else begin
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            auto_cnt_q <= auto_cnt_d;
        end
    end

    // ---------------------------------------------------------------- datapath
    assign cur_line   = idx_q[4:3];
    assign cur_digit  = idx_q[2:0];
    // Digit 0 is the most-significant nibble of the word.
    assign cur_nibble = shadow_q[cur_line][{~cur_digit, 2'b00} +: 4];

    nibble_to_ascii #(
        .UPPERCASE(UPPERCASE)
    ) u_nibble_to_ascii (
        .nibble_i(cur_nibble),
        .ascii_o (cur_ascii)
    );

    always_comb begin
        build_d = build_q;
        if (write_digit) begin
            build_d[cur_line][{~cur_digit, 3'b000} +: 8] = cur_ascii;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
            build_q  <= '0;
        end else begin
            if (capture) begin
                shadow_q <= {val3, val2, val1, val0};
            end
            build_q <= build_d;
        end
    end

    // Outputs load from build_d so the last nibble written on this edge is included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_axis_tdata_str1 <= '0;
            m_axis_tdata_str2 <= '0;
            m_axis_tdata_str3 <= '0;
            m_axis_tdata_str4 <= '0;
            m_axis_tvalid     <= 1'b0;
        end else begin
            if (load_out) begin
                m_axis_tdata_str1 <= make_line(2'd0, build_d[0]);
                m_axis_tdata_str2 <= make_line(2'd1, build_d[1]);
                m_axis_tdata_str3 <= make_line(2'd2, build_d[2]);
                m_axis_tdata_str4 <= make_line(2'd3, build_d[3]);
                m_axis_tvalid     <= 1'b1;
            end else if (handshake) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_oled_text_source.sv
// Directed bench for axis_oled_text_source: uppercase, lowercase and auto-refresh instances.
module tb_axis_oled_text_source;

    logic clk = 1'b0;
    logic reset;
    logic reset_a;
    logic [31:0] val0, val1, val2, val3;
    logic start;
    logic tready;

    logic         busy, tvalid;
    logic [127:0] s1, s2, s3, s4;
    logic         busy_lc, tvalid_lc;
    logic [127:0] l1, l2, l3, l4;
    logic         busy_a, tvalid_a;
    logic [127:0] a1, a2, a3, a4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axis_oled_text_source #(.UPPERCASE(1'b1), .AUTO_PERIOD(0)) dut (
        .clk(clk), .reset(reset), .val0(val0), .val1(val1), .val2(val2), .val3(val3),
        .start(start), .busy(busy), .m_axis_tdata_str1(s1), .m_axis_tdata_str2(s2),
        .m_axis_tdata_str3(s3), .m_axis_tdata_str4(s4), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready)
    );

    axis_oled_text_source #(.UPPERCASE(1'b0), .AUTO_PERIOD(0)) dut_lc (
        .clk(clk), .reset(reset), .val0(val0), .val1(val1), .val2(val2), .val3(val3),
        .start(start), .busy(busy_lc), .m_axis_tdata_str1(l1), .m_axis_tdata_str2(l2),
        .m_axis_tdata_str3(l3), .m_axis_tdata_str4(l4), .m_axis_tvalid(tvalid_lc),
        .m_axis_tready(tready)
    );

    axis_oled_text_source #(.UPPERCASE(1'b1), .AUTO_PERIOD(100)) dut_auto (
        .clk(clk), .reset(reset_a), .val0(val0), .val1(val1), .val2(val2), .val3(val3),
        .start(1'b0), .busy(busy_a), .m_axis_tdata_str1(a1), .m_axis_tdata_str2(a2),
        .m_axis_tdata_str3(a3), .m_axis_tdata_str4(a4), .m_axis_tvalid(tvalid_a),
        .m_axis_tready(1'b1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            cycles++;
            if (tvalid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; tready = 1'b1;
        val0 = '0; val1 = '0; val2 = '0; val3 = '0;
        repeat (2) tick();
        n_tests++;
        if (tvalid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: tvalid=%b busy=%b required 0/0", tvalid, busy);
        end
        n_tests++;
        if ({s1, s2, s3, s4} !== 512'd0) begin
            n_fail++;
            $display("FAIL reset_data: str1=%h required 0", s1);
        end
        reset = 1'b0;
        repeat (5) tick();
        n_tests++;
        if (busy !== 1'b0 || tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b tvalid=%b required 0/0", busy, tvalid);
        end
    endtask

    task automatic test_basic;
        logic [127:0] exp [4];
        logic [127:0] got [4];
        int  cycles;
        bit  ok;
        exp[0] = 128'h4348313A_20307844_45414442_45454620;
        exp[1] = "CH2: 0x00000000 ";
        exp[2] = "CH3: 0x0123ABCD ";
        exp[3] = "CH4: 0xCAFEF00D ";
        val0 = 32'hDEADBEEF; val1 = 32'h0; val2 = 32'h0123ABCD; val3 = 32'hCAFEF00D;
        tready = 1'b1;
        pulse_start();
        wait_valid(40, cycles, ok);
        n_tests++;
        if (!ok || cycles + 1 != 33) begin
            n_fail++;
            $display("FAIL latency: got %0d (valid=%b) required 33", cycles + 1, ok);
        end
        got[0] = s1; got[1] = s2; got[2] = s3; got[3] = s4;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (got[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL basic_str%0d: got %h required %h", i + 1, got[i], exp[i]);
            end
        end
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_in_valid: got %b required 1", busy);
        end
        tick();
        n_tests++;
        if (tvalid !== 1'b0 || busy !== 1'b0 || s1 !== exp[0]) begin
            n_fail++;
            $display("FAIL after_handshake: tvalid=%b busy=%b str1=%h", tvalid, busy, s1);
        end
    endtask

    task automatic test_lowercase;
        logic [127:0] e1, e2, e3, u1;
        int cycles;
        bit ok;
        e1 = "CH1: 0xfedcba98 ";
        e2 = "CH2: 0x00000000 ";
        e3 = "CH3: 0x0123abcd ";
        u1 = "CH1: 0xFEDCBA98 ";
        val0 = 32'hFEDCBA98; val1 = 32'h0; val2 = 32'h0123ABCD; val3 = 32'h0;
        tready = 1'b1;
        pulse_start();
        wait_valid(40, cycles, ok);
        n_tests++;
        if (!ok || tvalid_lc !== 1'b1) begin
            n_fail++;
            $display("FAIL lc_valid: got %b/%b required 1/1", ok, tvalid_lc);
        end
        n_tests++;
        if (l1 !== e1) begin
            n_fail++;
            $display("FAIL lc_str1: got %h required %h", l1, e1);
        end
        n_tests++;
        if (l2 !== e2) begin
            n_fail++;
            $display("FAIL lc_str2: got %h required %h", l2, e2);
        end
        n_tests++;
        if (l3 !== e3) begin
            n_fail++;
            $display("FAIL lc_str3: got %h required %h", l3, e3);
        end
        n_tests++;
        if (s1 !== u1) begin
            n_fail++;
            $display("FAIL uc_str1: got %h required %h", s1, u1);
        end
        tick();
    endtask

    task automatic test_backpressure;
        logic [127:0] e1;
        logic [511:0] snap;
        int cycles;
        bit ok, stable;
        e1 = "CH1: 0x13579BDF ";
        val0 = 32'h13579BDF; val1 = 32'h2468ACE0; val2 = 32'h5A5A5A5A; val3 = 32'hA5A5A5A5;
        tready = 1'b0;
        pulse_start();
        wait_valid(40, cycles, ok);
        n_tests++;
        if (!ok || s1 !== e1) begin
            n_fail++;
            $display("FAIL bp_first_beat: valid=%b str1=%h required %h", ok, s1, e1);
        end
        snap   = {s1, s2, s3, s4};
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tvalid !== 1'b1 || {s1, s2, s3, s4} !== snap) stable = 1'b0;
        end
        n_tests++;
        if (!stable) begin
            n_fail++;
            $display("FAIL bp_hold: got tvalid=%b stable=%b required 1/1", tvalid, stable);
        end
        tready = 1'b1;
        tick();
        n_tests++;
        if (tvalid !== 1'b0 || {s1, s2, s3, s4} !== snap) begin
            n_fail++;
            $display("FAIL bp_release: tvalid=%b str1=%h required 0/%h", tvalid, s1, e1);
        end
    endtask

    task automatic test_pending;
        logic [127:0] e_first, e_second;
        int cycles;
        bit ok, extra;
        e_first  = "CH1: 0xAAAAAAAA ";
        e_second = "CH1: 0x11111111 ";
        val0 = 32'hAAAAAAAA;
        tready = 1'b1;
        pulse_start();
        repeat (3) tick();
        val0 = 32'h11111111;
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            tick();
        end
        wait_valid(40, cycles, ok);
        n_tests++;
        if (!ok || s1 !== e_first) begin
            n_fail++;
            $display("FAIL pend_first: valid=%b str1=%h required %h", ok, s1, e_first);
        end
        wait_valid(40, cycles, ok);
        n_tests++;
        if (!ok || cycles != 34) begin
            n_fail++;
            $display("FAIL pend_gap: got %0d cycles (valid=%b) required 34", cycles, ok);
        end
        n_tests++;
        if (s1 !== e_second) begin
            n_fail++;
            $display("FAIL pend_second: got %h required %h", s1, e_second);
        end
        extra = 1'b0;
        tick();
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tvalid === 1'b1 || busy === 1'b1) extra = 1'b1;
        end
        n_tests++;
        if (extra) begin
            n_fail++;
            $display("FAIL pend_single: got extra beat required none");
        end
    endtask

    task automatic test_reset_mid;
        logic [127:0] exp [4];
        logic [127:0] got [4];
        int cycles;
        bit ok;
        exp[0] = "CH1: 0x01234567 ";
        exp[1] = "CH2: 0x89ABCDEF ";
        exp[2] = "CH3: 0xFFFFFFFF ";
        exp[3] = "CH4: 0x00000001 ";
        val0 = 32'h00C0FFEE; val1 = 32'hBAADF00D; val2 = 32'h0; val3 = 32'h0;
        tready = 1'b1;
        pulse_start();
        repeat (10) tick();
        reset = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || tvalid !== 1'b0 || {s1, s2, s3, s4} !== 512'd0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b tvalid=%b str1=%h required 0/0/0", busy, tvalid, s1);
        end
        tick();
        reset = 1'b0;
        val0 = 32'h01234567; val1 = 32'h89ABCDEF; val2 = 32'hFFFFFFFF; val3 = 32'h00000001;
        tick();
        pulse_start();
        wait_valid(40, cycles, ok);
        n_tests++;
        if (!ok || cycles + 1 != 33) begin
            n_fail++;
            $display("FAIL post_reset_latency: got %0d (valid=%b) required 33", cycles + 1, ok);
        end
        got[0] = s1; got[1] = s2; got[2] = s3; got[3] = s4;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (got[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL post_reset_str%0d: got %h required %h", i + 1, got[i], exp[i]);
            end
        end
        tick();
    endtask

    task automatic test_auto;
        logic [127:0] e1;
        int cycles;
        bit saw, ok;
        e1 = "CH1: 0x0000AB12 ";
        val0 = 32'h0000AB12;
        saw = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (tvalid_a !== 1'b0 || busy_a !== 1'b0) saw = 1'b1;
        end
        n_tests++;
        if (saw) begin
            n_fail++;
            $display("FAIL auto_in_reset: got activity required none");
        end
        reset_a = 1'b0;
        cycles = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            cycles++;
            if (tvalid_a === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok || cycles != 132) begin
            n_fail++;
            $display("FAIL auto_first: got %0d cycles (valid=%b) required 132", cycles, ok);
        end
        n_tests++;
        if (a1 !== e1) begin
            n_fail++;
            $display("FAIL auto_data: got %h required %h", a1, e1);
        end
        for (int p = 0; p < 2; p++) begin
            cycles = 0;
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                tick();
                cycles++;
                if (tvalid_a === 1'b0) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (ok) begin
                ok = 1'b0;
                for (int i = 0; i < 200; i++) begin
                    tick();
                    cycles++;
                    if (tvalid_a === 1'b1) begin
                        ok = 1'b1;
                        break;
                    end
                end
            end
            n_tests++;
            if (!ok || cycles != 133) begin
                n_fail++;
                $display("FAIL auto_period%0d: got %0d cycles (ok=%b) required 133", p, cycles, ok);
            end
        end
    endtask

    initial begin
        reset_a = 1'b1;
        test_reset();
        test_basic();
        test_lowercase();
        test_backpressure();
        test_pending();
        test_reset_mid();
        test_auto();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
